// File: rtl/tmds_rx_channel.sv
// ---------------------------------------------------------------------------
// tmds_rx_channel
//
// Receive side of one TMDS lane. Raw 10-bit words from an IDES10 deserializer
// are registered once, scanned for control tokens to find the word boundary
// (pulsing the deserializer bitslip input until a long token run is seen),
// and then decoded 10b->8b into pixel data, control bits and data enable.
//
// Ports:
//   I_rgb_clk    recovered pixel clock, sole clock domain
//   I_rst_n      asynchronous active-low reset
//   I_tmds_word  raw deserializer word, bit 0 is the first serial bit
//   O_bitslip    one-cycle pulse to the deserializer CALIB input
//   O_locked     word alignment achieved
//   O_de         data enable (1 = data period)
//   O_data       decoded pixel byte, valid when O_de = 1
//   O_ctrl       {C1,C0}, holds the last token value during data periods
// ---------------------------------------------------------------------------
module tmds_rx_channel #(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int MIN_TOKEN_RUN  = 16,
  parameter int SLIP_SETTLE    = 8
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds_word,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic       O_de,
  output logic [7:0] O_data,
  output logic [1:0] O_ctrl
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [7:0]  RUN_MAX      = 8'(MIN_TOKEN_RUN);
  localparam logic [7:0]  RUN_LAST     = 8'(MIN_TOKEN_RUN - 1);
  localparam logic [7:0]  SETTLE_LAST  = 8'(SLIP_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t      state;
  logic [9:0]  word_q;
  logic [7:0]  run_cnt;
  logic [15:0] timeout_cnt;
  logic [7:0]  settle_cnt;
  logic        is_token;
  logic [1:0]  token_ctrl;
  logic        qual_run;
  logic [7:0]  d_bits;
  logic [7:0]  decoded;

  // Single input register; everything downstream works from word_q.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= I_tmds_word;
    end
  end

  // Recognise the four control tokens and the {C1,C0} value each carries.
  always_comb begin
    is_token   = 1'b1;
    token_ctrl = 2'b00;
    case (word_q)
      10'b1101010100: token_ctrl = 2'b00;
      10'b0010101011: token_ctrl = 2'b01;
      10'b0101010100: token_ctrl = 2'b10;
      10'b1010101011: token_ctrl = 2'b11;
      default:        is_token   = 1'b0;
    endcase
  end

  // A qualifying run is the single cycle on which the run counter would
  // step from MIN_TOKEN_RUN-1 to MIN_TOKEN_RUN; a saturated counter does
  // not requalify. Input is ignored while settling after a slip.
  assign qual_run = is_token && (run_cnt == RUN_LAST) && (state != ST_SETTLE);

  // 10b->8b decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    d_bits     = word_q[9] ? ~word_q[7:0] : word_q[7:0];
    decoded    = '0;
    decoded[0] = d_bits[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = word_q[8] ? (d_bits[i] ^ d_bits[i-1]) : ~(d_bits[i] ^ d_bits[i-1]);
    end
  end

  // Consecutive-token run counter, saturating, cleared by any data word
  // and held at zero while the deserializer settles after a slip.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      run_cnt <= '0;
    end else if (state == ST_SETTLE) begin
      run_cnt <= '0;
    end else if (is_token) begin
      if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 8'd1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  // Alignment FSM. A qualifying run always takes priority over a timeout
  // expiring on the same cycle. Losing lock returns to SEARCH without a
  // slip, so the next slip needs a full fresh search timeout.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= ST_SEARCH;
      timeout_cnt <= '0;
      settle_cnt  <= '0;
      O_bitslip   <= 1'b0;
      O_locked    <= 1'b0;
    end else begin
      O_bitslip <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (qual_run) begin
            state       <= ST_LOCKED;
            O_locked    <= 1'b1;
            timeout_cnt <= '0;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state       <= ST_SETTLE;
            O_bitslip   <= 1'b1;
            timeout_cnt <= '0;
            settle_cnt  <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        ST_SETTLE: begin
          timeout_cnt <= '0;
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SEARCH;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (qual_run) begin
            timeout_cnt <= '0;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state       <= ST_SEARCH;
            O_locked    <= 1'b0;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: begin
          state       <= ST_SEARCH;
          O_locked    <= 1'b0;
          timeout_cnt <= '0;
          settle_cnt  <= '0;
        end
      endcase
    end
  end

  // Registered decode outputs. Nothing is presented until aligned; while
  // locked, tokens update the control bits and data words leave them held.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de   <= 1'b0;
      O_data <= '0;
      O_ctrl <= '0;
    end else if (state == ST_LOCKED) begin
      if (is_token) begin
        O_de   <= 1'b0;
        O_data <= '0;
        O_ctrl <= token_ctrl;
      end else begin
        O_de   <= 1'b1;
        O_data <= decoded;
      end
    end else begin
      O_de   <= 1'b0;
      O_data <= '0;
      O_ctrl <= '0;
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// ---------------------------------------------------------------------------
// tb_tmds_rx_channel
//
// Self-checking bench for tmds_rx_channel. A behavioural deserializer model
// rotates the transmitted word by the current bit phase and advances that
// phase whenever the DUT pulses O_bitslip. Inputs change on the falling
// edge; outputs are read on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_tmds_rx_channel;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam int NV = 10;

  typedef struct {
    logic [9:0] word;
    logic       exp_de;
    logic [7:0] exp_data;
    logic [1:0] exp_ctrl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds_word;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   phase = 0;
  int   slip_total = 0;
  vec_t vecs [NV];

  tmds_rx_channel dut (
    .I_rgb_clk  (clk),
    .I_rst_n    (rst_n),
    .I_tmds_word(tmds_word),
    .O_bitslip  (bitslip),
    .O_locked   (locked),
    .O_de       (de),
    .O_data     (data),
    .O_ctrl     (ctrl)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // Deserializer output for a given bit phase of the serial stream.
  function automatic logic [9:0] rot(input logic [9:0] w, input int s);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[i] = w[(i + s) % 10];
    end
    return r;
  endfunction

  // One cycle: wait for the falling edge, let the deserializer model react
  // to a slip pulse, then present the next transmitted word.
  task automatic applyStimulus(input logic [9:0] word);
    @(negedge clk);
    cyc++;
    if (bitslip === 1'b1) begin
      slip_total++;
      phase = (phase + 1) % 10;
    end
    tmds_word = rot(word, phase);
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    int tok_step;
    int early_slip;
    int seen;
    int last_slip;
    int short_gap;
    int late_slip;
    int lock_drop;
    int early_lock;
    int slips_start;

    vecs[0] = '{10'h100, 1'b1, 8'h00, 2'b00};
    vecs[1] = '{10'h2FF, 1'b1, 8'hFE, 2'b00};
    vecs[2] = '{TOK11,   1'b0, 8'h00, 2'b11};
    vecs[3] = '{10'h100, 1'b1, 8'h00, 2'b11};
    vecs[4] = '{10'h2FF, 1'b1, 8'hFE, 2'b11};
    vecs[5] = '{TOK01,   1'b0, 8'h00, 2'b01};
    vecs[6] = '{TOK10,   1'b0, 8'h00, 2'b10};
    vecs[7] = '{10'h055, 1'b1, 8'h01, 2'b10};
    vecs[8] = '{10'h3F0, 1'b1, 8'h11, 2'b10};
    vecs[9] = '{10'h0B4, 1'b1, 8'h22, 2'b10};

    rst_n     = 1'b1;
    tmds_word = 10'h100;
    #2 rst_n  = 1'b0;

    $display("[TB] reset state");
    for (int i = 0; i < 3; i++) applyStimulus(10'h100);
    checkOutput("rst_bitslip", 16'(bitslip), 16'h0);
    checkOutput("rst_locked", 16'(locked), 16'h0);
    checkOutput("rst_de", 16'(de), 16'h0);
    checkOutput("rst_data", 16'(data), 16'h00);
    checkOutput("rst_ctrl", 16'(ctrl), 16'h0);
    rst_n = 1'b1;

    $display("[TB] aligned token run");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(TOK00);
      if (i == 16) checkOutput("lock_before", 16'(locked), 16'h0);
      if (i == 17) checkOutput("lock_after", 16'(locked), 16'h1);
    end
    checkOutput("lock_ctrl", 16'(ctrl), 16'h0);
    applyStimulus(10'h100);
    applyStimulus(10'h100);
    checkOutput("de_latency1", 16'(de), 16'h0);
    applyStimulus(10'h100);
    checkOutput("de_latency2", 16'(de), 16'h1);
    checkOutput("data_latency2", 16'(data), 16'h00);
    checkOutput("aligned_no_slip", 16'(slip_total), 16'h0);

    $display("[TB] decode vectors");
    for (int i = 0; i < NV + 2; i++) begin
      applyStimulus(i < NV ? vecs[i].word : 10'h100);
      if (i >= 2) begin
        checkOutput($sformatf("vec%0d_de", i - 2), 16'(de), 16'(vecs[i-2].exp_de));
        checkOutput($sformatf("vec%0d_data", i - 2), 16'(data), 16'(vecs[i-2].exp_data));
        checkOutput($sformatf("vec%0d_ctrl", i - 2), 16'(ctrl), 16'(vecs[i-2].exp_ctrl));
      end
    end

    $display("[TB] lock timeout");
    for (int i = 0; i < 16; i++) applyStimulus(TOK00);
    tok_step   = cyc;
    early_slip = 0;
    while (cyc < tok_step + 8196) begin
      applyStimulus(10'h100);
      if (cyc == tok_step + 4097) checkOutput("timeout_still_locked", 16'(locked), 16'h1);
      if (cyc == tok_step + 4098) checkOutput("timeout_unlocked", 16'(locked), 16'h0);
      if (cyc < tok_step + 8194 && bitslip === 1'b1) early_slip++;
      if (cyc == tok_step + 8194) checkOutput("first_slip", 16'(bitslip), 16'h1);
      if (cyc == tok_step + 8195) checkOutput("slip_one_cycle", 16'(bitslip), 16'h0);
    end
    checkOutput("no_early_slip", 16'(early_slip), 16'h0);

    $display("[TB] rotated stream alignment");
    rst_n = 1'b0;
    phase = 7;
    applyStimulus(TOK00);
    applyStimulus(TOK00);
    rst_n       = 1'b1;
    slips_start = slip_total;
    seen        = 0;
    last_slip   = 0;
    short_gap   = 0;
    for (int n = 0; n < 20000 && locked !== 1'b1; n++) begin
      applyStimulus(TOK00);
      if (bitslip === 1'b1) begin
        if (seen > 0 && (cyc - last_slip) < 9) short_gap++;
        last_slip = cyc;
        seen++;
      end
    end
    checkOutput("rot_locked", 16'(locked), 16'h1);
    checkOutput("rot_slip_count", 16'(seen), 16'h3);
    checkOutput("rot_settle_gap", 16'(short_gap), 16'h0);
    checkOutput("rot_phase", 16'(phase), 16'h0);
    late_slip = 0;
    lock_drop = 0;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(TOK00);
      if (bitslip === 1'b1) late_slip++;
      if (locked !== 1'b1) lock_drop++;
    end
    checkOutput("rot_no_extra_slip", 16'(late_slip), 16'h0);
    checkOutput("rot_stays_locked", 16'(lock_drop), 16'h0);
    checkOutput("rot_model_slips", 16'(slip_total - slips_start), 16'h3);

    $display("[TB] mid-data reset");
    for (int n = 0; n < 3; n++) applyStimulus(10'h2FF);
    checkOutput("pre_rst_de", 16'(de), 16'h1);
    checkOutput("pre_rst_data", 16'(data), 16'hFE);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_locked", 16'(locked), 16'h0);
    checkOutput("mid_rst_de", 16'(de), 16'h0);
    checkOutput("mid_rst_data", 16'(data), 16'h00);
    checkOutput("mid_rst_ctrl", 16'(ctrl), 16'h0);
    checkOutput("mid_rst_bitslip", 16'(bitslip), 16'h0);
    applyStimulus(10'h2FF);
    applyStimulus(10'h2FF);
    rst_n      = 1'b1;
    early_lock = 0;
    for (int n = 0; n < 15; n++) begin
      applyStimulus(TOK00);
      if (locked === 1'b1) early_lock++;
    end
    for (int n = 0; n < 10; n++) begin
      applyStimulus(10'h2FF);
      if (locked === 1'b1) early_lock++;
    end
    checkOutput("relock_short_run", 16'(early_lock), 16'h0);
    for (int n = 0; n < 16; n++) applyStimulus(TOK00);
    applyStimulus(10'h2FF);
    applyStimulus(10'h2FF);
    checkOutput("relock_full_run", 16'(locked), 16'h1);
    applyStimulus(10'h2FF);
    checkOutput("relock_de", 16'(de), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
